// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one SPI master engine between several requesters.
// Latches the winner's word, drives its slave-select, triggers the engine and returns the result.
module spi_master_scheduler #(
  parameter int requesters   = 4,
  parameter int bitcount     = 8,
  parameter bit ss_polarity  = 1'b1,
  parameter int guard_cycles = 2,
  parameter int start_limit  = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [requesters-1:0]          request_i,
  input  logic [requesters*bitcount-1:0] tx_data_i,
  output logic [requesters-1:0]          grant_o,
  output logic [requesters-1:0]          done_o,
  output logic                           error_o,
  output logic [bitcount-1:0]            rx_data_o,
  output logic [requesters-1:0]          ss_o,
  output logic                           engine_trigger_o,
  output logic [bitcount-1:0]            engine_data_o,
  input  logic                           engine_busy_i,
  input  logic [bitcount-1:0]            engine_rx_i
);

  localparam int PtrW   = $clog2(requesters);
  localparam int CntMax = (start_limit > guard_cycles) ? start_limit : guard_cycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] StartLast = CntW'(start_limit - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(guard_cycles - 1);
  localparam logic [PtrW-1:0] LastReq   = PtrW'(requesters - 1);

  typedef enum logic [2:0] {Idle, Setup, Start, Transfer, Guard} state_e;

  state_e                  state_q, state_d;
  logic [requesters-1:0]   grant_q, grant_d;
  logic [requesters-1:0]   done_q, done_d;
  logic                    error_q, error_d;
  logic                    trigger_q, trigger_d;
  logic [bitcount-1:0]     engine_data_q, engine_data_d;
  logic [bitcount-1:0]     rx_data_q, rx_data_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [PtrW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    found;
  logic [PtrW-1:0]         winner;
  int                      idx;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= Idle;
      grant_q       <= '0;
      done_q        <= '0;
      error_q       <= 1'b0;
      trigger_q     <= 1'b0;
      engine_data_q <= '0;
      rx_data_q     <= '0;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      error_q       <= error_d;
      trigger_q     <= trigger_d;
      engine_data_q <= engine_data_d;
      rx_data_q     <= rx_data_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    done_d        = '0;
    error_d       = 1'b0;
    trigger_d     = 1'b0;
    engine_data_d = engine_data_q;
    rx_data_d     = rx_data_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    found         = 1'b0;
    winner        = ptr_q;
    idx           = 0;

    // Scan starting at the pointer so the last owner gets lowest priority.
    for (int k = 0; k < requesters; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= requesters) idx = idx - requesters;
      if (!found && request_i[idx]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end

    case (state_q)
      Idle: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          engine_data_d   = tx_data_i[winner*bitcount +: bitcount];
          state_d         = Setup;
        end
      end
      Setup: begin
        trigger_d = 1'b1;
        cnt_d     = '0;
        state_d   = Start;
      end
      Start: begin
        if (engine_busy_i) begin
          state_d = Transfer;
        end else if (cnt_q == StartLast) begin
          done_d  = grant_q;
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = Guard;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Transfer: begin
        if (!engine_busy_i) begin
          rx_data_d = engine_rx_i;
          done_d    = grant_q;
          cnt_d     = '0;
          state_d   = Guard;
        end
      end
      Guard: begin
        if (cnt_q == GuardLast) begin
          grant_d = '0;
          ptr_d   = (owner_q == LastReq) ? '0 : owner_q + PtrW'(1);
          state_d = Idle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Slave-select follows the grant only while the wire is actually in use.
  assign ss_o = (state_q == Setup || state_q == Start || state_q == Transfer)
                ? (grant_q ^ {requesters{~ss_polarity}})
                : {requesters{~ss_polarity}};

  assign grant_o          = grant_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign rx_data_o        = rx_data_q;
  assign engine_trigger_o = trigger_q;
  assign engine_data_o    = engine_data_q;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Directed bench for spi_master_scheduler: transaction-timeline model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_spi_master_scheduler;

  localparam int N     = 4;
  localparam int BITS  = 8;
  localparam int GUARD = 2;
  localparam int SL    = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    request = '0;
  logic [N*BITS-1:0] txData = '0;
  logic [N-1:0]    grant, done, ss;
  logic            error, engineTrigger;
  logic [BITS-1:0] rxData, engineData;
  logic            engineBusy = 1'b0;
  logic [BITS-1:0] engineRx = '0;
  logic            engineStuck = 1'b0;
  int              engTimer = 0;

  int checks = 0;
  int errors = 0;

  spi_master_scheduler #(
    .requesters(N), .bitcount(BITS), .ss_polarity(1'b1),
    .guard_cycles(GUARD), .start_limit(SL)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .request_i(request),
    .tx_data_i(txData),
    .grant_o(grant),
    .done_o(done),
    .error_o(error),
    .rx_data_o(rxData),
    .ss_o(ss),
    .engine_trigger_o(engineTrigger),
    .engine_data_o(engineData),
    .engine_busy_i(engineBusy),
    .engine_rx_i(engineRx)
  );

  always #5 clock = ~clock;

  // Echoing engine: busy for BITS clocks after a trigger, unless stuck.
  always @(posedge clock) begin
    #1;
    if (engTimer > 0) begin
      engTimer = engTimer - 1;
      if (engTimer == 0) engineBusy = 1'b0;
    end else if (engineTrigger === 1'b1 && !engineStuck) begin
      engineBusy = 1'b1;
      engTimer   = BITS;
      engineRx   = engineData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: a grant starting at cycle mG lasts mDn cycles to done, then GUARD more.
  int           cyc = 0;
  bit           mKnown = 0, mActive = 0, mStuck = 0, mFound;
  int           mG, mDn, mOwner, mPtr = 0, mIdx, off;
  logic [BITS-1:0] mWord, mRx = '0;
  logic [N-1:0] expGrant, expSs, expDone;
  logic         expTrig, expErr;

  always @(negedge clock) begin
    cyc++;
    if (mKnown) begin
      expGrant = '0; expSs = '0; expDone = '0; expTrig = 1'b0; expErr = 1'b0;
      if (mActive) begin
        off = cyc - mG;
        if (off < mDn + GUARD) expGrant = N'(1) << mOwner;
        if (off < mDn) expSs = expGrant;
        expTrig = (off == 1);
        if (off == mDn) begin
          expDone = expGrant;
          expErr  = mStuck;
          if (!mStuck) mRx = mWord;
        end
        checkOutput("engine_data", 32'(engineData), 32'(mWord));
      end
      checkOutput("grant", 32'(grant), 32'(expGrant));
      checkOutput("ss", 32'(ss), 32'(expSs));
      checkOutput("trigger", 32'(engineTrigger), 32'(expTrig));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("error", 32'(error), 32'(expErr));
      checkOutput("rx_data", 32'(rxData), 32'(mRx));
      checkOutput("ss onehot", 32'($countones(ss) <= 1), 32'(1));
    end
    if (reset) begin
      mKnown = 1; mActive = 0; mPtr = 0; mRx = '0;
    end else if (mKnown) begin
      if (mActive) begin
        if (cyc - mG == mDn + GUARD - 1) begin
          mActive = 0;
          mPtr    = (mOwner + 1) % N;
        end
      end else if (request != 0) begin
        mFound = 0;
        for (int k = 0; k < N; k++) begin
          mIdx = (mPtr + k) % N;
          if (!mFound && request[mIdx]) begin
            mFound = 1;
            mOwner = mIdx;
          end
        end
        mActive = 1;
        mG      = cyc + 1;
        mStuck  = engineStuck;
        mDn     = mStuck ? SL + 1 : BITS + 2;
        mWord   = txData[mOwner*BITS +: BITS];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N*BITS-1:0] tx);
    request = req;
    txData  = tx;
  endtask

  task automatic doReset();
    tick();
    reset   = 1'b1;
    request = '0;
    tick();
    reset   = 1'b0;
  endtask

  task automatic waitGrant(output logic [N-1:0] g);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (grant != 0 && n < 60);
    while (grant == 0 && n < 120) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait grant timeout", 32'(grant == 0), 32'(0));
    g = grant;
  endtask

  task automatic waitDone(output logic [N-1:0] d);
    int n = 0;
    while (done == 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait done timeout", 32'(done == 0), 32'(0));
    d = done;
  endtask

  task automatic waitTrigger(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!engineTrigger && k < 30);
  endtask

  task automatic countGuard(output int g);
    g = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (grant == 0) break;
      g++;
    end
  endtask

  initial begin
    logic [N-1:0] g, d;
    int k, t, gc, doneCnt;
    int order2[5] = '{0, 1, 2, 3, 0};

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset grant", 32'(grant), 32'(0));
    checkOutput("reset ss", 32'(ss), 32'(0));
    checkOutput("reset rx_data", 32'(rxData), 32'(0));
    checkOutput("reset engine_data", 32'(engineData), 32'(0));

    // Single requester with echoing engine.
    tick();
    applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'hA5});
    waitTrigger(k);
    checkOutput("t1 request-to-trigger", 32'(k - 1), 32'(2));
    checkOutput("t1 ss at trigger", 32'(ss), 32'b0001);
    waitDone(d);
    checkOutput("t1 done", 32'(d), 32'b0001);
    checkOutput("t1 rx_data", 32'(rxData), 32'hA5);
    checkOutput("t1 error", 32'(error), 32'(0));
    checkOutput("t1 ss in done cycle", 32'(ss), 32'(0));
    tick();
    request = '0;
    countGuard(gc);
    checkOutput("t1 guard length", 32'(gc), 32'(GUARD));

    // All four requesting from a fresh pointer.
    doReset();
    tick();
    applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
    for (int i = 0; i < 5; i++) begin
      waitGrant(g);
      checkOutput("t2 grant order", 32'(g), 32'(N'(1) << order2[i]));
      waitDone(d);
      checkOutput("t2 done matches grant", 32'(d), 32'(g));
      if (i == 4) begin
        tick();
        request = '0;
      end
    end

    // Pointer is now 1: requester 2 must win before requester 0.
    tick();
    applyStimulus(4'b0101, {8'h44, 8'h33, 8'h22, 8'h11});
    waitGrant(g);
    checkOutput("t3 first grant", 32'(g), 32'b0100);
    waitDone(d);
    waitGrant(g);
    checkOutput("t3 second grant", 32'(g), 32'b0001);
    waitDone(d);
    tick();
    request = '0;

    // Engine never starts.
    engineStuck = 1'b1;
    applyStimulus(4'b0010, {8'h44, 8'h33, 8'h22, 8'h11});
    waitTrigger(k);
    t = 0;
    while (done == 0 && t < 30) begin
      @(negedge clock);
      t++;
    end
    checkOutput("t4 trigger-to-done", 32'(t), 32'(SL));
    checkOutput("t4 done", 32'(done), 32'b0010);
    checkOutput("t4 error", 32'(error), 32'(1));
    checkOutput("t4 rx_data unchanged", 32'(rxData), 32'h11);
    tick();
    request = '0;
    countGuard(gc);
    checkOutput("t4 guard length", 32'(gc), 32'(GUARD));
    engineStuck = 1'b0;

    // Reset in the middle of a transfer.
    tick();
    applyStimulus(4'b1000, {8'hC3, 8'h33, 8'h5A, 8'h11});
    waitTrigger(k);
    repeat (3) @(negedge clock);
    tick();
    reset   = 1'b1;
    request = '0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("t5 grant after reset", 32'(grant), 32'(0));
    checkOutput("t5 ss after reset", 32'(ss), 32'(0));
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done != 0) doneCnt++;
    end
    checkOutput("t5 no done after reset", 32'(doneCnt), 32'(0));
    tick();
    applyStimulus(4'b1010, {8'hC3, 8'h33, 8'h5A, 8'h11});
    waitGrant(g);
    checkOutput("t5 rearbitration from 0", 32'(g), 32'b0010);
    waitDone(d);
    tick();
    request = '0;

    // Requester withdraws during the transfer.
    tick();
    applyStimulus(4'b0100, {8'hC3, 8'h77, 8'h5A, 8'h11});
    waitTrigger(k);
    repeat (2) @(negedge clock);
    tick();
    request = '0;
    doneCnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done != 0) begin
        doneCnt++;
        checkOutput("t6 done owner", 32'(done), 32'b0100);
      end
    end
    checkOutput("t6 done count", 32'(doneCnt), 32'(1));
    checkOutput("t6 rx_data", 32'(rxData), 32'h77);
    checkOutput("t6 not regranted", 32'(grant), 32'(0));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
